multicycle_controller: RTL
==========================

# multicycle_controller

Main control FSM that sequences the team's ARM-subset datapath in multicycle form: one shared instruction/data memory, an instruction register, and a single ALU reused across cycles. It decodes the latched instruction fields and owns the architectural NZCV flags register. It evaluates the condition field and drives every datapath write enable and mux select. It also stalls on a memory ready handshake so variable-latency memory can sit behind the datapath.

## Interface
Parameters: none (widths fixed by the ISA).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instruction_cond  in  4  instruction[31:28], from instruction register
- instruction_op  in  2  instruction[27:26]
- instruction_funct  in  6  instruction[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
- instruction_rd  in  4  instruction[15:12]
- alu_flags  in  4  {N,Z,C,V} from ALU, current cycle
- memory_ready  in  1  memory completes the current access this cycle
- memory_request  out  1  memory access active
- memory_write  out  1  store strobe
- address_source  out  1  0=PC, 1=ALU output register
- instruction_write  out  1  load instruction register
- program_counter_write  out  1  PC register enable
- register_write  out  1  register file write enable
- register_source  out  2  [0]=1 for branch, [1]=1 for memory op
- immediate_source  out  2  equals instruction_op
- alu_source_a  out  1  0=Rn, 1=PC
- alu_source_b  out  2  00=RD2, 01=extended immediate, 10=constant 4
- alu_control  out  2  00 add, 01 sub, 10 and, 11 orr
- result_source  out  2  00=ALU output register, 01=read data register, 10=ALU result
- flags  out  4  architectural {N,Z,C,V}
- state  out  4  current FSM state encoding, for debug

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9. Encodings 10-15 are unused and go to FETCH on the next cycle.
- FETCH:
  - Drive memory_request=1, address_source=0, alu_source_a=1, alu_source_b=10, alu_control=00, result_source=10.
  - When memory_ready=1: pulse instruction_write and program_counter_write, then go to DECODE. Otherwise hold in FETCH.
- DECODE:
  - Drive alu_source_a=1, alu_source_b=10 (PC+8 reaches the ALU output register).
  - Next state by instruction_op: 01 goes to MEMADR; 00 goes to EXECUTEI if funct[5]=1, else EXECUTER; 10 goes to BRANCH; 11 goes to FETCH as a no-op.
- MEMADR: alu_source_b=01, alu_control=00. Go to MEMREAD if funct[0]=1, else MEMWRITE.
- MEMREAD: memory_request=1, address_source=1. Hold until memory_ready, then go to MEMWB.
- MEMWRITE:
  - memory_request=1, address_source=1, memory_write=cond_ex.
  - If cond_ex=0, return to FETCH at once with no request.
  - Otherwise hold until memory_ready, then go to FETCH.
- MEMWB: result_source=01, register_write=cond_ex. Go to FETCH.
- EXECUTER / EXECUTEI: alu_source_b=00 / 01, alu_control decoded from cmd. Go to ALUWB.
- ALUWB: result_source=00, register_write=cond_ex and cmd supported. Go to FETCH.
- BRANCH: alu_source_b=01, result_source=10, program_counter_write=cond_ex. Go to FETCH.
- PC as destination: in MEMWB/ALUWB with instruction_rd=15 and cond_ex, also assert program_counter_write. Keep register_write as specified.
- cmd decode: 0100 gives ADD (00), 0010 SUB (01), 0000 AND (10), 1100 ORR (11). Any other cmd gives alu_control=00 and is "unsupported", which suppresses register and flag writes.
- Condition codes: cond_ex is evaluated combinationally from instruction_cond and the flags register. Implement all 14 ARM conditions EQ..LE plus AL (1110). 1111 gives cond_ex=0.
- Flag update: happens at the end of EXECUTER/EXECUTEI when cond_ex, S=1 and cmd is supported.
  - ADD/SUB write all of NZCV.
  - AND/ORR write NZ only; C and V are kept.
- register_source and immediate_source are combinational from instruction_op in every state.

## Timing
- Reset: state=FETCH, flags=0000. While reset is high, every write enable and memory_request is 0. The first fetch request is issued in the cycle after reset deasserts.
- Reset mid-operation overrides everything: a pending load or store is abandoned and memory_write is 0 from the next edge onward.
- Latency with zero wait states: LDR 5 cycles, STR 4, data-processing 4, B 3, op=11 2.
  - Each FETCH/MEMREAD/MEMWRITE cycle with memory_ready=0 adds exactly one cycle.
- memory_ready is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored elsewhere.
- Control outputs are Moore-style, apart from the cond_ex gating, the FETCH strobes gated by memory_ready, and the rd=15 check. These are combinational within the same cycle.
- Flags written at the edge ending EXECUTE are visible to the cond_ex of the next instruction, never the current one.

## Test plan
- Reset, then ADD R1,R2,#5 with memory_ready tied 1 → state trace 0,1,7,8,0. register_write is high only in ALUWB, alu_control=00, alu_source_b=01.
- SUBS R0,R0,R0 with alu_flags=0110 → flags=0110 after EXECUTER. A following BEQ drives program_counter_write=1 in BRANCH; a following BNE keeps it at 0.
- LDR with memory_ready low for 3 cycles in MEMREAD → the FSM holds in state 3 for 4 cycles total, MEMWB follows, and the whole instruction takes 8 cycles.
- STRNE with Z=1 → MEMWRITE asserts no memory_write and returns to FETCH in 1 cycle without waiting on memory_ready.
- ANDS with alu_flags=1011 on prior flags 0000 → flags=1000 (C and V preserved). An unsupported cmd 1111 with S=1 leaves flags and the registers unchanged.
- Reset asserted in MEMWRITE while memory_ready=0 → next cycle state=FETCH, memory_write=0, flags=0000.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle ARM-subset datapath: sequences fetch/decode/execute,
// evaluates condition codes against the NZCV flags register and drives every datapath enable.
module multicycle_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] instruction_cond,
  input  logic [1:0] instruction_op,
  input  logic [5:0] instruction_funct,
  input  logic [3:0] instruction_rd,
  input  logic [3:0] alu_flags,
  input  logic       memory_ready,
  output logic       memory_request,
  output logic       memory_write,
  output logic       address_source,
  output logic       instruction_write,
  output logic       program_counter_write,
  output logic       register_write,
  output logic [1:0] register_source,
  output logic [1:0] immediate_source,
  output logic       alu_source_a,
  output logic [1:0] alu_source_b,
  output logic [1:0] alu_control,
  output logic [1:0] result_source,
  output logic [3:0] flags,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic       funct_i_bit;
  logic [3:0] funct_cmd;
  logic       funct_s_bit;
  logic       cond_ex;
  logic       cmd_supported;
  logic [1:0] dp_alu_control;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign funct_i_bit = instruction_funct[5];
  assign funct_cmd   = instruction_funct[4:1];
  assign funct_s_bit = instruction_funct[0];

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Condition evaluation uses the architectural flags only, never this cycle's ALU flags.
  always_comb begin
    case (instruction_cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // NOTE: every signal assigned in a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    dp_alu_control = 2'b00;
    cmd_supported  = 1'b1;
    case (funct_cmd)
      4'b0100: dp_alu_control = 2'b00;
      4'b0010: dp_alu_control = 2'b01;
      4'b0000: dp_alu_control = 2'b10;
      4'b1100: dp_alu_control = 2'b11;
      default: cmd_supported  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (memory_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (instruction_op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct_i_bit ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct_s_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (memory_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (!cond_ex || memory_ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Logical ops leave C and V alone; arithmetic ops overwrite all four flags.
  always_comb begin
    flags_d = flags_q;
    if ((state_q == S_EXECUTER || state_q == S_EXECUTEI) &&
        cond_ex && funct_s_bit && cmd_supported) begin
      if (dp_alu_control[1]) flags_d[3:2] = alu_flags[3:2];
      else                   flags_d     = alu_flags;
    end
  end

  always_comb begin
    memory_request        = 1'b0;
    memory_write          = 1'b0;
    address_source        = 1'b0;
    instruction_write     = 1'b0;
    program_counter_write = 1'b0;
    register_write        = 1'b0;
    alu_source_a          = 1'b0;
    alu_source_b          = 2'b00;
    alu_control           = 2'b00;
    result_source         = 2'b00;
    case (state_q)
      S_FETCH: begin
        memory_request        = 1'b1;
        alu_source_a          = 1'b1;
        alu_source_b          = 2'b10;
        result_source         = 2'b10;
        instruction_write     = memory_ready;
        program_counter_write = memory_ready;
      end
      S_DECODE: begin
        alu_source_a = 1'b1;
        alu_source_b = 2'b10;
      end
      S_MEMADR:   alu_source_b = 2'b01;
      S_MEMREAD: begin
        memory_request = 1'b1;
        address_source = 1'b1;
      end
      S_MEMWRITE: begin
        memory_request = cond_ex;
        memory_write   = cond_ex;
        address_source = 1'b1;
      end
      S_MEMWB: begin
        result_source         = 2'b01;
        register_write        = cond_ex;
        program_counter_write = cond_ex && (instruction_rd == 4'd15);
      end
      S_EXECUTER:   alu_control = dp_alu_control;
      S_EXECUTEI: begin
        alu_source_b = 2'b01;
        alu_control  = dp_alu_control;
      end
      S_ALUWB: begin
        register_write        = cond_ex && cmd_supported;
        program_counter_write = cond_ex && (instruction_rd == 4'd15);
      end
      S_BRANCH: begin
        alu_source_b          = 2'b01;
        result_source         = 2'b10;
        program_counter_write = cond_ex;
      end
      default: ;
    endcase
    // Reset silences every side effect immediately, including an in-flight store.
    if (reset) begin
      memory_request        = 1'b0;
      memory_write          = 1'b0;
      instruction_write     = 1'b0;
      program_counter_write = 1'b0;
      register_write        = 1'b0;
    end
  end

  assign register_source  = {instruction_op == 2'b01, instruction_op == 2'b10};
  assign immediate_source = instruction_op;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign state = state_q;
  assign flags = flags_q;

endmodule
